// File: rtl/reg_view_sequencer_pkg.sv
// rtl/reg_view_sequencer_pkg.sv - shared state encoding and pair addressing helpers
package reg_view_sequencer_pkg;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_PEND = 1'b1;

  // Pair index is one bit narrower than a register address; kept at least 1 bit wide.
  function automatic int pair_idx_w(input int nregs);
    int w;
    w = $clog2(nregs) - 1;
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int unsigned pair_addr(input int unsigned idx, input logic odd);
    return (idx << 1) | {31'd0, odd};
  endfunction

endpackage

// File: rtl/reg_view_sequencer_tick_gen.sv
// rtl/reg_view_sequencer_tick_gen.sv - free-running PERIOD counter with restart and expire pulse
module tick_gen #(
  parameter int PERIOD = 50_000_000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_restart,
  output logic o_expire
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_term;

  assign w_term   = (r_cnt == CW'(PERIOD - 1));
  assign o_expire = w_term;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_restart || w_term) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/reg_view_sequencer.sv
// rtl/reg_view_sequencer.sv - display read scheduler sharing the register file read ports with the CPU
module reg_view_sequencer
  import reg_view_sequencer_pkg::*;
#(
  parameter int NREGS        = 16,
  parameter int DATA_W       = 16,
  parameter int PERIOD       = 50_000_000,
  parameter int STARVE_LIMIT = 255,
  localparam int AW          = $clog2(NREGS),
  localparam int PW          = pair_idx_w(NREGS)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_step,
  input  logic              i_auto_en,
  input  logic              i_cpu_req,
  input  logic [AW-1:0]     i_cpu_r_addr,
  input  logic [AW-1:0]     i_cpu_s_addr,
  input  logic [DATA_W-1:0] i_rf_R,
  input  logic [DATA_W-1:0] i_rf_S,
  output logic [AW-1:0]     o_rf_r_addr,
  output logic [AW-1:0]     o_rf_s_addr,
  output logic [DATA_W-1:0] o_disp_R,
  output logic [DATA_W-1:0] o_disp_S,
  output logic [PW-1:0]     o_view_idx,
  output logic              o_stall_cpu
);

  localparam int WW       = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int LAST_IDX = NREGS / 2 - 1;

  state_t            r_state;
  logic              r_step_q;
  logic [PW-1:0]     r_view_idx;
  logic [WW-1:0]     r_wait_cnt;
  logic              r_stall;
  logic [DATA_W-1:0] r_disp_R;
  logic [DATA_W-1:0] r_disp_S;

  logic          w_edge;
  logic          w_expire;
  logic          w_adv;
  logic [PW-1:0] w_idx_nxt;
  logic [WW-1:0] w_wait_nxt;

  assign w_edge = i_step & ~r_step_q;
  // An edge coinciding with an auto expiry is still one advance.
  assign w_adv  = w_edge | (w_expire & i_auto_en);

  assign w_idx_nxt  = (r_view_idx == PW'(LAST_IDX)) ? '0 : r_view_idx + PW'(1);
  assign w_wait_nxt = (r_wait_cnt == WW'(STARVE_LIMIT)) ? r_wait_cnt : r_wait_cnt + WW'(1);

  tick_gen #(
    .PERIOD(PERIOD)
  ) u_tick_gen (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_restart(w_edge),
    .o_expire (w_expire)
  );

  always_comb begin
    o_rf_r_addr = AW'(pair_addr(32'(r_view_idx), 1'b0));
    o_rf_s_addr = AW'(pair_addr(32'(r_view_idx), 1'b1));
    if (i_cpu_req) begin
      o_rf_r_addr = i_cpu_r_addr;
      o_rf_s_addr = i_cpu_s_addr;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_PEND;
      r_step_q   <= 1'b0;
      r_view_idx <= '0;
      r_wait_cnt <= '0;
      r_stall    <= 1'b0;
      r_disp_R   <= '0;
      r_disp_S   <= '0;
    end else begin
      r_step_q <= i_step;
      if (w_adv) begin
        r_view_idx <= w_idx_nxt;
      end
      if (r_state == ST_IDLE) begin
        if (w_adv || w_expire) begin
          r_state <= ST_PEND;
        end
      end else if (!i_cpu_req) begin
        r_disp_R   <= i_rf_R;
        r_disp_S   <= i_rf_S;
        r_wait_cnt <= '0;
        r_stall    <= 1'b0;
        // An advance landing on the capture edge keeps the read pending for the new pair.
        r_state    <= w_adv ? ST_PEND : ST_IDLE;
      end else begin
        r_wait_cnt <= w_wait_nxt;
        if (w_wait_nxt == WW'(STARVE_LIMIT)) begin
          r_stall <= 1'b1;
        end
      end
    end
  end

  assign o_disp_R    = r_disp_R;
  assign o_disp_S    = r_disp_S;
  assign o_view_idx  = r_view_idx;
  assign o_stall_cpu = r_stall;

endmodule

// File: tb/tb_reg_view_sequencer.sv
// tb/tb_reg_view_sequencer.sv - directed self-checking bench for reg_view_sequencer
module tb_reg_view_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        step;
  logic        auto_en;
  logic        cpu_req;
  logic [3:0]  cpu_r_addr;
  logic [3:0]  cpu_s_addr;
  logic [15:0] rf_R;
  logic [15:0] rf_S;
  logic [3:0]  rf_r_addr;
  logic [3:0]  rf_s_addr;
  logic [15:0] disp_R;
  logic [15:0] disp_S;
  logic [2:0]  view_idx;
  logic        stall_cpu;

  logic [15:0] rf [16];
  int n_tests = 0;
  int n_fail  = 0;
  int c;

  always #5 clk = ~clk;

  assign rf_R = rf[rf_r_addr];
  assign rf_S = rf[rf_s_addr];

  reg_view_sequencer #(
    .NREGS(16), .DATA_W(16), .PERIOD(8), .STARVE_LIMIT(4)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_step(step), .i_auto_en(auto_en),
    .i_cpu_req(cpu_req), .i_cpu_r_addr(cpu_r_addr), .i_cpu_s_addr(cpu_s_addr),
    .i_rf_R(rf_R), .i_rf_S(rf_S), .o_rf_r_addr(rf_r_addr), .o_rf_s_addr(rf_s_addr),
    .o_disp_R(disp_R), .o_disp_S(disp_S), .o_view_idx(view_idx), .o_stall_cpu(stall_cpu)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_change(output int cyc);
    logic [2:0] prev;
    prev = view_idx;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (view_idx == prev && cyc < 40);
  endtask

  initial begin
    reset = 1'b1; step = 1'b0; auto_en = 1'b0; cpu_req = 1'b0;
    cpu_r_addr = 4'd0; cpu_s_addr = 4'd0;
    for (int i = 0; i < 16; i++) rf[i] = 16'(16'h1111 * i);
    rf[0] = 16'hAAAA;
    rf[1] = 16'h5555;

    @(negedge clk);
    chk("rst_r_addr", 32'(rf_r_addr), 32'd0);
    chk("rst_s_addr", 32'(rf_s_addr), 32'd1);
    chk("rst_idx", 32'(view_idx), 32'd0);
    chk("rst_disp_R", 32'(disp_R), 32'd0);
    chk("rst_disp_S", 32'(disp_S), 32'd0);
    chk("rst_stall", 32'(stall_cpu), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("boot_disp_R", 32'(disp_R), 32'hAAAA);
    chk("boot_disp_S", 32'(disp_S), 32'h5555);

    // Uncontended step: index on the first edge, display on the second.
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("step_idx", 32'(view_idx), 32'd1);
    chk("step_r_addr", 32'(rf_r_addr), 32'd2);
    chk("step_s_addr", 32'(rf_s_addr), 32'd3);
    chk("step_disp_old", 32'(disp_R), 32'hAAAA);
    @(negedge clk);
    chk("step_disp_R", 32'(disp_R), 32'h2222);
    chk("step_disp_S", 32'(disp_S), 32'h3333);

    // Seven more steps wrap to pair 0; the first is held high for three cycles.
    for (int k = 0; k < 7; k++) begin
      step = 1'b1;
      repeat ((k == 0) ? 3 : 1) @(negedge clk);
      step = 1'b0;
      repeat (2) @(negedge clk);
      chk("wrap_idx", 32'(view_idx), 32'((k + 2) % 8));
      chk("wrap_disp_R", 32'(disp_R), 32'(rf[2 * ((k + 2) % 8)]));
    end
    chk("wrap_disp_S", 32'(disp_S), 32'h5555);

    // Contended read: CPU owns the ports, stall rises after 4 waiting cycles.
    cpu_req = 1'b1; cpu_r_addr = 4'd5; cpu_s_addr = 4'd9; step = 1'b1;
    #1;
    chk("cpu_r_addr", 32'(rf_r_addr), 32'd5);
    chk("cpu_s_addr", 32'(rf_s_addr), 32'd9);
    @(negedge clk);
    step = 1'b0;
    chk("cont_idx", 32'(view_idx), 32'd1);
    chk("cont_stall0", 32'(stall_cpu), 32'd0);
    repeat (3) @(negedge clk);
    chk("cont_stall3", 32'(stall_cpu), 32'd0);
    chk("cont_disp_hold", 32'(disp_R), 32'hAAAA);
    @(negedge clk);
    chk("cont_stall4", 32'(stall_cpu), 32'd1);
    repeat (3) @(negedge clk);
    chk("cont_stall_sat", 32'(stall_cpu), 32'd1);
    cpu_req = 1'b0;
    #1;
    chk("release_r_addr", 32'(rf_r_addr), 32'd2);
    @(negedge clk);
    chk("release_disp_R", 32'(disp_R), 32'h2222);
    chk("release_disp_S", 32'(disp_S), 32'h3333);
    chk("release_stall", 32'(stall_cpu), 32'd0);

    // Auto advance every PERIOD cycles.
    auto_en = 1'b1;
    wait_change(c);
    chk("auto_idx2", 32'(view_idx), 32'd2);
    wait_change(c);
    chk("auto_period", 32'(c), 32'd8);
    chk("auto_idx3", 32'(view_idx), 32'd3);
    repeat (7) @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("coincide_idx", 32'(view_idx), 32'd4);
    wait_change(c);
    chk("coincide_period", 32'(c), 32'd8);
    chk("auto_idx5", 32'(view_idx), 32'd5);
    repeat (3) @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("midstep_idx", 32'(view_idx), 32'd6);
    wait_change(c);
    chk("restart_period", 32'(c), 32'd8);
    chk("auto_idx7", 32'(view_idx), 32'd7);

    // Refresh mode: index frozen, changed register data appears within 9 cycles.
    auto_en = 1'b0;
    rf[14] = 16'hBEEF;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (disp_R != 16'hBEEF && c < 12);
    chk("refresh_disp_R", 32'(disp_R), 32'hBEEF);
    chk("refresh_in_time", 32'(c <= 9), 32'd1);
    repeat (10) @(negedge clk);
    chk("refresh_idx", 32'(view_idx), 32'd7);

    // Asynchronous reset during a stalled pending read.
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    chk("pre_rst_idx", 32'(view_idx), 32'd0);
    chk("pre_rst_disp", 32'(disp_R), 32'hAAAA);
    cpu_req = 1'b1; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_stall", 32'(stall_cpu), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_stall", 32'(stall_cpu), 32'd0);
    chk("arst_idx", 32'(view_idx), 32'd0);
    chk("arst_disp_R", 32'(disp_R), 32'd0);
    chk("arst_disp_S", 32'(disp_S), 32'd0);
    cpu_req = 1'b0;
    #1;
    chk("arst_s_addr", 32'(rf_s_addr), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_disp_R", 32'(disp_R), 32'hAAAA);
    chk("post_rst_disp_S", 32'(disp_S), 32'h5555);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
